rr_reg_arbiter: RTL and testbench
=================================

// Module: rr_reg_arbiter
// PURPOSE
//  Round-robin arbiter that shares one W-bit D flip-flop register among N requesters.
//  Each requester presents write data and a request.
//  The arbiter grants one requester at a time and loads that requester's data into the
//  shared register. It then acknowledges the write.
//  The block sits in front of the flip-flop storage and is its only writer.
// PARAMETERS
//  N   4  number of requesters (>=2)
//  W   8  width of shared register and of each wdata slice
//  IW  $clog2(N)  index width (derived localparam, not overridable)
// PORTS
//  clk    in   1      rising-edge clock
//  rst    in   1      reset, asynchronous, active-high
//  req    in   N      request per requester; held high until ack
//  wdata  in   N*W    write data; slice i = wdata[i*W +: W]
//  gnt    out  N      one-hot grant; all zero when idle
//  ack    out  N      one-hot, one-cycle pulse: write to q completed
//  q      out  W      shared register contents
//  owner  out  IW     index of last requester that wrote q
//  valid  out  1      q holds written data (0 after reset until first write)
// BEHAVIOUR
//  - Reset: one clock domain (clk); rst is asynchronous and active-high. Reset forces
//    the following while rst is high, independent of clk:
//    - state=IDLE, gnt=0, ack=0, q=0, owner=0, valid=0, ptr=0.
//  - FSM, two states:
//    - IDLE: ack may be high here for exactly one cycle (from the previous write).
//      - If req != 0, select the winner g = first set bit of req searching
//        ptr, ptr+1, ... N-1, 0, ... ptr-1 (mod N).
//      - Register gnt = onehot(g) and go to GRANT. If req == 0, stay in IDLE.
//    - GRANT: gnt held for exactly one cycle, then the FSM always returns to IDLE.
//      - If req[g] is still high at the closing edge (normal write):
//        q <= wdata slice g; owner <= g; valid <= 1; ack <= onehot(g);
//        ptr <= (g+1) mod N; gnt <= 0.
//      - If req[g] is low at the closing edge (abandoned): no write, no ack;
//        q, owner, valid and ptr unchanged; gnt <= 0.
//  - Latency: with req sampled at edge k, gnt is high in cycle k..k+1.
//    q and ack update at edge k+1. ack is high for the cycle after edge k+1.
//  - Throughput: at most one write per 2 cycles. With requests held continuously,
//    grants recur every 2 cycles.
//  - ack and gnt are never high in the same cycle. At most one bit of each is set.
//  - A requester that keeps req high after its ack is eligible again. It now has the
//    lowest priority because ptr has moved past it.
//  - The winner is fixed when gnt is registered. New requests arriving during GRANT
//    wait for the next IDLE cycle.
//  - ptr wraps from N-1 to 0. There is no priority bias except through ptr.
//  - wdata is sampled only at the GRANT closing edge. It may change at any other time.
//  - Reset during GRANT: outputs clear immediately, the pending write is discarded,
//    and no ack is issued.
//  - A reset release close to a clk edge is the integrator's responsibility.
//    No synchroniser is included.
// TESTING  (N=4, W=8, 10 ns clock; rst high 0-3 ns, then low unless stated)
//  1. Reset: rst high from t=0 with random req/wdata -> gnt=0, ack=0, q=0x00,
//     owner=0, valid=0 throughout. Also assert rst again at an arbitrary mid-cycle
//     time -> all outputs clear immediately, before the next clk edge.
//  2. Single write: req=0010, wdata slice1=0xA5 -> gnt=0010 for one cycle, then
//     q=0xA5, owner=1, valid=1, ack=0010 for one cycle. Drop req on ack -> gnt stays 0.
//  3. Fairness: req=1111 held, slices 0x10/0x21/0x32/0x43 -> grant order 0,1,2,3,0.
//     q steps 0x10, 0x21, 0x32, 0x43, 0x10, one write every 2 cycles.
//  4. Abandon: req=0100; deassert req[2] while gnt=0100 -> no ack, q/owner/valid
//     unchanged, ptr unchanged. Re-raising req=0100 then gets granted normally.
//  5. Wrap-around: after a write by requester 3 (ptr=0), raise req=1001 -> requester 0
//     wins. Next, requester 3 wins.
//  6. Reset mid-GRANT: req=0001, wdata slice0=0xFF; pulse rst 2 ns after gnt rises ->
//     gnt=0, no ack, q=0x00, valid=0. After release, the held req=0001 is granted again.

Source files
------------

// File: rtl/rr_reg_arbiter.sv
// rr_reg_arbiter: round-robin arbiter, sole writer of one shared W-bit register
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous active-high reset
//   req    per-requester request, held until ack
//   wdata  per-requester write data, slice i = wdata[i*W +: W]
//   gnt    one-hot grant, one cycle per arbitration
//   ack    one-hot one-cycle pulse after the register is written
//   q      shared register contents
//   owner  index of the last requester that wrote q
//   valid  q holds written data
module rr_reg_arbiter #(
   parameter int N = 4,
   parameter int W = 8,
   localparam int IW = $clog2(N)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   req,
   input  logic [N*W-1:0] wdata,
   output logic [N-1:0]   gnt,
   output logic [N-1:0]   ack,
   output logic [W-1:0]   q,
   output logic [IW-1:0]  owner,
   output logic           valid
);
   typedef enum logic {IDLE, GRANT} state_t;
   state_t state;
   logic [IW-1:0] ptr, cur, win;
   logic hit;
   // first requester at or after ptr, wrapping modulo N
   always_comb begin
      win = '0;
      hit = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (!hit && req[(int'(ptr) + k) % N]) begin
            win = IW'((int'(ptr) + k) % N);
            hit = 1'b1;
         end
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         gnt   <= '0;
         ack   <= '0;
         q     <= '0;
         owner <= '0;
         valid <= 1'b0;
         ptr   <= '0;
         cur   <= '0;
      end else begin
         ack <= '0;
         if (state == IDLE) begin
            if (hit) begin
               gnt   <= N'(1) << win;
               cur   <= win;
               state <= GRANT;
            end
         end else begin
            gnt   <= '0;
            state <= IDLE;
            // a requester that dropped req during its grant forfeits the write
            if (req[cur]) begin
               q     <= wdata[int'(cur)*W +: W];
               owner <= cur;
               valid <= 1'b1;
               ack   <= gnt;
               ptr   <= IW'((int'(cur) + 1) % N);
            end
         end
      end
   end
endmodule

// File: tb/tb_rr_reg_arbiter.sv
// tb_rr_reg_arbiter: vectors, corner sequences and random traffic against a transaction model
module tb_rr_reg_arbiter;
   localparam int N = 4;
   localparam int W = 8;
   logic clk, rst;
   logic [N-1:0] req, gnt, ack;
   logic [N*W-1:0] wdata;
   logic [W-1:0] q;
   logic [1:0] owner;
   logic valid;
   int n_chk = 0, n_fail = 0;
   int m_g, m_a, m_q, m_owner, m_valid, m_ptr;
   typedef struct {
      bit rb;
      logic [3:0] r;
      logic [31:0] d;
      logic [3:0] g, a;
      logic [7:0] eq;
      logic [1:0] o;
      logic v;
   } vec_t;
   vec_t tbl[14];

   rr_reg_arbiter #(.N(N), .W(W)) dut (
      .clk(clk), .rst(rst), .req(req), .wdata(wdata),
      .gnt(gnt), .ack(ack), .q(q), .owner(owner), .valid(valid)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int pick(input logic [N-1:0] r);
      for (int k = 0; k < N; k++)
         if (r[(m_ptr + k) % N]) return (m_ptr + k) % N;
      return -1;
   endfunction

   task automatic model_reset();
      m_g = -1; m_a = -1; m_q = 0; m_owner = 0; m_valid = 0; m_ptr = 0;
   endtask

   // one transaction step per edge: an outstanding grant resolves, otherwise a new one may start
   task automatic model_edge();
      if (m_g >= 0) begin
         m_a = -1;
         if (req[m_g]) begin
            m_q = int'(wdata[m_g*W +: W]);
            m_owner = m_g;
            m_valid = 1;
            m_a = m_g;
            m_ptr = (m_g + 1) % N;
         end
         m_g = -1;
      end else begin
         m_a = -1;
         m_g = pick(req);
      end
   endtask

   task automatic zero_chk(input string nm);
      chk({nm, " gnt"}, gnt, 0);
      chk({nm, " ack"}, ack, 0);
      chk({nm, " q"}, q, 0);
      chk({nm, " owner"}, owner, 0);
      chk({nm, " valid"}, valid, 0);
   endtask

   task automatic check_model();
      chk("model gnt", gnt, m_g < 0 ? 0 : (1 << m_g));
      chk("model ack", ack, m_a < 0 ? 0 : (1 << m_a));
      chk("model q", q, m_q);
      chk("model owner", owner, m_owner);
      chk("model valid", valid, m_valid);
      chk("gnt ack overlap", int'(|(gnt & ack)), 0);
   endtask

   task automatic cyc(input logic [N-1:0] r, input logic [N*W-1:0] d);
      req = r;
      wdata = d;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_model();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req = N'($urandom);
      wdata = $urandom;
      @(posedge clk);
      #1 zero_chk("reset over edge");
      req = '0;
      rst = 1'b0;
      model_reset();
      @(negedge clk);
   endtask

   initial begin
      logic [N-1:0] r;
      rst = 1'b1;
      req = N'($urandom);
      wdata = $urandom;
      model_reset();
      #1 zero_chk("reset t1");
      #1 zero_chk("reset t2");
      #1 rst = 1'b0;
      req = '0;
      @(negedge clk);
      check_model();

      tbl[0]  = '{1, 4'b0010, 32'h0000A500, 4'b0010, 4'b0000, 8'h00, 2'd0, 1'b0};
      tbl[1]  = '{0, 4'b0010, 32'h0000A500, 4'b0000, 4'b0010, 8'hA5, 2'd1, 1'b1};
      tbl[2]  = '{0, 4'b0000, 32'h0000A500, 4'b0000, 4'b0000, 8'hA5, 2'd1, 1'b1};
      tbl[3]  = '{0, 4'b0000, 32'h00000000, 4'b0000, 4'b0000, 8'hA5, 2'd1, 1'b1};
      tbl[4]  = '{1, 4'b1111, 32'h43322110, 4'b0001, 4'b0000, 8'h00, 2'd0, 1'b0};
      tbl[5]  = '{0, 4'b1111, 32'h43322110, 4'b0000, 4'b0001, 8'h10, 2'd0, 1'b1};
      tbl[6]  = '{0, 4'b1111, 32'h43322110, 4'b0010, 4'b0000, 8'h10, 2'd0, 1'b1};
      tbl[7]  = '{0, 4'b1111, 32'h43322110, 4'b0000, 4'b0010, 8'h21, 2'd1, 1'b1};
      tbl[8]  = '{0, 4'b1111, 32'h43322110, 4'b0100, 4'b0000, 8'h21, 2'd1, 1'b1};
      tbl[9]  = '{0, 4'b1111, 32'h43322110, 4'b0000, 4'b0100, 8'h32, 2'd2, 1'b1};
      tbl[10] = '{0, 4'b1111, 32'h43322110, 4'b1000, 4'b0000, 8'h32, 2'd2, 1'b1};
      tbl[11] = '{0, 4'b1111, 32'h43322110, 4'b0000, 4'b1000, 8'h43, 2'd3, 1'b1};
      tbl[12] = '{0, 4'b1111, 32'h43322110, 4'b0001, 4'b0000, 8'h43, 2'd3, 1'b1};
      tbl[13] = '{0, 4'b1111, 32'h43322110, 4'b0000, 4'b0001, 8'h10, 2'd0, 1'b1};
      for (int i = 0; i < 14; i++) begin
         if (tbl[i].rb) do_reset();
         cyc(tbl[i].r, tbl[i].d);
         chk($sformatf("vec%0d gnt", i), gnt, tbl[i].g);
         chk($sformatf("vec%0d ack", i), ack, tbl[i].a);
         chk($sformatf("vec%0d q", i), q, tbl[i].eq);
         chk($sformatf("vec%0d owner", i), owner, tbl[i].o);
         chk($sformatf("vec%0d valid", i), valid, tbl[i].v);
      end

      cyc(4'b0100, 32'h00770000);
      chk("abandon gnt", gnt, 4'b0100);
      cyc(4'b0000, 32'h00770000);
      chk("abandon ack", ack, 0);
      chk("abandon q", q, 8'h10);
      chk("abandon owner", owner, 0);
      chk("abandon valid", valid, 1);
      cyc(4'b0100, 32'h00770000);
      chk("regrant gnt", gnt, 4'b0100);
      cyc(4'b0100, 32'h00770000);
      chk("regrant ack", ack, 4'b0100);
      chk("regrant q", q, 8'h77);

      cyc(4'b1000, 32'h99000000);
      cyc(4'b1000, 32'h99000000);
      chk("wrap write3", ack, 4'b1000);
      cyc(4'b1001, 32'h990000AA);
      chk("wrap first", gnt, 4'b0001);
      cyc(4'b1001, 32'h990000AA);
      chk("wrap q", q, 8'hAA);
      cyc(4'b1001, 32'h990000AA);
      chk("wrap second", gnt, 4'b1000);
      cyc(4'b0000, 32'h0);

      req = 4'b0001;
      wdata = 32'h000000FF;
      @(posedge clk);
      #2 chk("midgrant gnt up", gnt, 4'b0001);
      rst = 1'b1;
      #1 zero_chk("midgrant reset");
      #1 rst = 1'b0;
      model_reset();
      @(negedge clk);
      check_model();
      cyc(4'b0001, 32'h000000FF);
      chk("post reset gnt", gnt, 4'b0001);
      cyc(4'b0001, 32'h000000FF);
      chk("post reset q", q, 8'hFF);

      r = '0;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) r = N'($urandom);
         cyc(r, $urandom);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
